simple_proc_ctrl: RTL
=====================

SIMPLE_PROC_CTRL -- requirements
Module: simple_proc_ctrl

Interface
REQ-001 Parameter: EXEC_WAIT, 1, number of cycles (1..4) operands are held on the ALU before the result r is sampled.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 instr  input  8  instruction: op[7:6], rd[5:4], rx[3:2], ry[1:0]; LOAD immediate = instr[2:0].
REQ-005 instr_valid  input  1  instr is presented this cycle.
REQ-006 instr_ready  output  1  controller can accept an instruction this cycle.
REQ-007 p  output  3  ALU operand A (value of register rx).
REQ-008 q  output  3  ALU operand B (value of register ry).
REQ-009 addsub  output  1  ALU subtract-result select.
REQ-010 XOR_enable  output  1  ALU XOR-result select.
REQ-011 r  input  3  ALU result, combinational from p, q, addsub, XOR_enable.
REQ-012 result  output  3  value written to rd by the completing instruction.
REQ-013 result_valid  output  1  one-cycle pulse marking result and register write.
REQ-014 dbg_sel  input  2  register index for debug read.
REQ-015 dbg_data  output  3  combinational value of register dbg_sel.

Function
REQ-016 Register file SHALL be four 3-bit registers R0..R3, all writable, with no hard-wired zero.
REQ-017 Opcodes SHALL be: 00 LOAD (rd = imm), 01 MOV (rd = rx), 10 SUB (rd = rx - ry mod 8), 11 XOR (rd = rx ^ ry).
REQ-018 FSM states SHALL be IDLE, EXEC and WB.
REQ-019 instr_ready SHALL be 1 only in IDLE; an instruction is accepted on the edge where instr_valid & instr_ready.
REQ-020 instr_valid while not in IDLE SHALL be ignored; the source holds instr until accepted.
REQ-021 On acceptance, LOAD and MOV SHALL go IDLE -> WB; SUB and XOR SHALL go IDLE -> EXEC.
REQ-022 The controller SHALL latch the decoded fields and the operand values of rx and ry at acceptance.
REQ-023 EXEC SHALL last exactly EXEC_WAIT cycles, counted by an internal counter, then go to WB.
REQ-024 During EXEC and WB, p and q SHALL hold the latched operands.
REQ-025 During EXEC and WB, SUB SHALL drive addsub=1, XOR_enable=0, and XOR SHALL drive addsub=0, XOR_enable=1.
REQ-026 In IDLE, and for LOAD and MOV, p, q, addsub and XOR_enable SHALL be 0.
REQ-027 WB SHALL last one cycle and then go to IDLE.
REQ-028 On the WB edge, rd SHALL be written: imm for LOAD, latched rx for MOV, and r sampled in WB for SUB and XOR.
REQ-029 result_valid SHALL be 1 for exactly the WB cycle, with result equal to the value being written.
REQ-030 result SHALL hold its last value outside WB.
REQ-031 Latency from the accept edge to result_valid SHALL be 1 cycle for LOAD and MOV, and EXEC_WAIT+1 cycles for SUB and XOR.
REQ-032 Throughput SHALL be one instruction per (latency+1) cycles; ready SHALL be reasserted in the cycle after WB.
REQ-033 rd equal to rx or ry SHALL be legal: operands come from pre-write values, and the next instruction sees the written value.
REQ-034 dbg_data SHALL reflect a write in the cycle after the WB edge.
REQ-035 SUB underflow SHALL wrap modulo 8 with no flag.

Reset
REQ-036 With resetn=0 at an edge, the FSM SHALL go to IDLE, the EXEC counter to 0, R0..R3 to 0, result to 0 and result_valid to 0.
REQ-037 After that reset edge, p, q, addsub and XOR_enable SHALL be 0.
REQ-038 Reset asserted in EXEC or WB SHALL abort the instruction with no register write and no result_valid pulse.
REQ-039 instr_ready SHALL be 0 while resetn=0 and 1 in the first cycle after release.

Verification
REQ-040 LOAD R1=5, then LOAD R2=3, then SUB R3=R1-R2 (EXEC_WAIT=1) -> result_valid pulses with result=5, 3, 2; SUB pulse 2 cycles after its accept; dbg_sel=3 reads 2.
REQ-041 R1=2, R2=5, SUB R0=R1-R2 -> result=5 (wrap); XOR R0=R0^R2 with R0=6, R2=3 -> result=5; addsub/XOR_enable = 1/0 then 0/1 during the respective EXEC and WB.
REQ-042 Hold instr_valid=1 continuously with back-to-back instructions -> each accepted only in IDLE, none lost or duplicated, ready low during EXEC and WB.
REQ-043 EXEC_WAIT=3, XOR -> p and q stable for 4 cycles; result_valid 4 cycles after accept.
REQ-044 SUB R1=R1-R1 with R1=4 -> result=0; a following MOV R2=R1 -> result=0.
REQ-045 Assert resetn=0 during EXEC of SUB -> no result_valid pulse; all registers read 0; ready=1 one cycle after release.

Source files
------------

// File: rtl/simple_proc_ctrl.sv
// Sequencing controller for a 3-bit register machine driving an external combinational ALU.
// Decodes LOAD/MOV/SUB/XOR, holds ALU operands for EXEC_WAIT cycles, then writes back.
//
// state | meaning
// IDLE  | ready for an instruction; ALU outputs parked at 0
// EXEC  | SUB/XOR operands and select held on the ALU, down-counter running
// WB    | destination register written, result_valid pulsed
module simple_proc_ctrl #(
  parameter int EXEC_WAIT = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic [2:0] p,
  output logic [2:0] q,
  output logic       addsub,
  output logic       XOR_enable,
  input  logic [2:0] r,
  output logic [2:0] result,
  output logic       result_valid,
  input  logic [1:0] dbg_sel,
  output logic [2:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  // Counter is loaded with EXEC_WAIT-1 so terminal count 0 marks the last EXEC cycle.
  localparam logic [1:0] CNT_INIT = 2'(EXEC_WAIT - 1);

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [1:0] op_q, rd_q;
  logic [2:0] imm_q, opa_q, opb_q;
  logic [2:0] regs [4];
  logic [2:0] result_q;
  logic [2:0] wdata;
  logic       alu_on;
  logic       busy;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      op_q     <= OP_LOAD;
      rd_q     <= 2'd0;
      imm_q    <= 3'd0;
      opa_q    <= 3'd0;
      opb_q    <= 3'd0;
      result_q <= 3'd0;
      for (int i = 0; i < 4; i++) regs[i] <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && instr_valid) begin
        op_q  <= instr[7:6];
        rd_q  <= instr[5:4];
        imm_q <= instr[2:0];
        opa_q <= regs[instr[3:2]];
        opb_q <= regs[instr[1:0]];
      end
      if (state == WB) begin
        regs[rd_q] <= wdata;
        result_q   <= wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          state_nxt = instr[7] ? EXEC : WB;
          cnt_nxt   = CNT_INIT;
        end
      end
      EXEC: begin
        busy = 1'b1;
        if (cnt == 2'd0) state_nxt = WB;
        else             cnt_nxt   = cnt - 2'd1;
      end
      WB: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_on     = busy && op_q[1];
    p          = alu_on ? opa_q : 3'd0;
    q          = alu_on ? opb_q : 3'd0;
    addsub     = alu_on && (op_q == OP_SUB);
    XOR_enable = alu_on && (op_q == OP_XOR);
    case (op_q)
      OP_LOAD: wdata = imm_q;
      OP_MOV:  wdata = opa_q;
      default: wdata = r;
    endcase
  end

  // Handshake outputs are masked by resetn so an aborted WB never shows a pulse.
  assign instr_ready  = (state == IDLE) && resetn;
  assign result_valid = (state == WB) && resetn;
  assign result       = result_valid ? wdata : result_q;
  assign dbg_data     = regs[dbg_sel];

endmodule
